// File: rtl/a2d_seq.sv
// a2d_seq: round-robin A2D conversion sequencer.
// Selects the next enabled logical slot, runs command/read SPI transaction
// pairs for each sample, averages 2^AVG_LOG2 samples and publishes the
// result into that slot's field of the result bus.
//
// SPI handshake: snd is a one-cycle request pulse and cmd is held stable
// for the whole burst. done is a level that the SPI master holds until it
// samples the next snd, so done is ignored in any cycle where snd is high
// (that level belongs to the previous transaction). A done outside that
// cycle completes the transaction just started.
module a2d_seq #(
    parameter int                  NUM_CH   = 4,
    parameter logic [NUM_CH*3-1:0] CH_MAP   = {3'd4, 3'd3, 3'd1, 3'd0},
    parameter int                  PERIOD_W = 14,
    parameter int                  AVG_LOG2 = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 auto_en,
    input  logic                 trig,
    input  logic [NUM_CH-1:0]    ch_en,
    output logic                 snd,
    output logic [15:0]          cmd,
    input  logic                 done,
    input  logic [15:0]          resp,
    output logic [NUM_CH*12-1:0] result,
    output logic [NUM_CH-1:0]    upd,
    output logic                 busy
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW = 12 + AVG_LOG2;
    localparam int SW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [SW-1:0] SCNT_LAST = SW'((1 << AVG_LOG2) - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_READ = 3'd3;
    localparam logic [2:0] S_PUB  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [PERIOD_W-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        cur_q, cur_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [SW-1:0]        scnt_q, scnt_d;
    logic                 snd_q, snd_d;
    logic [15:0]          cmd_q, cmd_d;
    logic [NUM_CH*12-1:0] result_q, result_d;
    logic [NUM_CH-1:0]    upd_q, upd_d;

    logic          tick;
    logic          start;
    logic          done_ok;
    logic          hi_found, lo_found;
    logic [CW-1:0] hi_idx, lo_idx;
    logic          sel_any;
    logic [CW-1:0] sel_idx;
    logic [2:0]    sel_ch;
    logic [CW-1:0] ptr_next;
    logic [11:0]   avg;
    logic          resp_unused;

    // Only the 12-bit conversion field of the SPI response carries data.
    assign resp_unused = ^resp[15:12];

    // Interval tick, start request and qualified transaction completion.
    always_comb begin
        tick    = &cnt_q;
        start   = ((tick & auto_en) | trig) & sel_any;
        done_ok = done & ~snd_q;
    end

    // First enabled slot at or above ptr, otherwise the lowest enabled slot
    // below ptr: a circular search starting at ptr.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (ch_en[j]) begin
                if (CW'(j) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = CW'(j);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = CW'(j);
                end
            end
        end
        sel_any = hi_found | lo_found;
        sel_idx = hi_found ? hi_idx : lo_idx;
    end

    // Physical ADC channel for the selected slot.
    always_comb begin
        sel_ch = 3'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_idx == CW'(k)) begin
                sel_ch = CH_MAP[3*k +: 3];
            end
        end
    end

    // Pointer advance past the slot being published, and the averaged value.
    always_comb begin
        if (cur_q == CW'(NUM_CH - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = cur_q + CW'(1);
        end
        avg = 12'(acc_q >> AVG_LOG2);
    end

    // Sequencer next-state logic: one sample is CMD, GAP, READ; the last
    // sample of a burst goes through PUB to write its slot.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + PERIOD_W'(1);
        ptr_d    = ptr_q;
        cur_d    = cur_q;
        acc_d    = acc_q;
        scnt_d   = scnt_q;
        snd_d    = 1'b0;
        cmd_d    = cmd_q;
        result_d = result_q;
        upd_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CMD;
                    snd_d   = 1'b1;
                    cur_d   = sel_idx;
                    cmd_d   = {2'b00, sel_ch, 11'h000};
                end
            end
            S_CMD: begin
                if (done_ok) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                snd_d   = 1'b1;
                state_d = S_READ;
            end
            S_READ: begin
                if (done_ok) begin
                    acc_d  = acc_q + AW'(resp[11:0]);
                    scnt_d = scnt_q + SW'(1);
                    if (scnt_q == SCNT_LAST) begin
                        state_d = S_PUB;
                    end else begin
                        state_d = S_CMD;
                        snd_d   = 1'b1;
                    end
                end
            end
            S_PUB: begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (cur_q == CW'(k)) begin
                        result_d[12*k +: 12] = avg;
                        upd_d[k]             = 1'b1;
                    end
                end
                acc_d   = '0;
                scnt_d  = '0;
                ptr_d   = ptr_next;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any burst and discards partial sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            cur_q    <= '0;
            acc_q    <= '0;
            scnt_q   <= '0;
            snd_q    <= 1'b0;
            cmd_q    <= 16'h0000;
            result_q <= '0;
            upd_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            cur_q    <= cur_d;
            acc_q    <= acc_d;
            scnt_q   <= scnt_d;
            snd_q    <= snd_d;
            cmd_q    <= cmd_d;
            result_q <= result_d;
            upd_q    <= upd_d;
        end
    end

    assign snd    = snd_q;
    assign cmd    = cmd_q;
    assign result = result_q;
    assign upd    = upd_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_a2d_seq.sv
// Bench for a2d_seq: two instances (no averaging / 4-sample averaging),
// each served by a small SPI master model that holds done until it has
// seen the next snd, returning 0xEEE for command transactions and a
// known conversion value for read transactions.
`timescale 1ns/1ps
module tb_a2d_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    // ---------------- instance 0: AVG_LOG2 = 0 ----------------
    logic        auto_en0 = 1'b0;
    logic        trig0    = 1'b0;
    logic [3:0]  ch_en0   = 4'h0;
    logic        snd0;
    logic [15:0] cmd0;
    logic        done0    = 1'b0;
    logic [15:0] resp0    = 16'h0;
    logic [47:0] result0;
    logic [3:0]  upd0;
    logic        busy0;

    a2d_seq #(
        .NUM_CH(4), .CH_MAP({3'd4, 3'd3, 3'd1, 3'd0}), .PERIOD_W(6), .AVG_LOG2(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .auto_en(auto_en0), .trig(trig0), .ch_en(ch_en0),
        .snd(snd0), .cmd(cmd0), .done(done0), .resp(resp0),
        .result(result0), .upd(upd0), .busy(busy0)
    );

    // ---------------- instance 1: AVG_LOG2 = 2 ----------------
    logic        auto_en1 = 1'b0;
    logic        trig1    = 1'b0;
    logic [3:0]  ch_en1   = 4'h0;
    logic        snd1;
    logic [15:0] cmd1;
    logic        done1    = 1'b0;
    logic [15:0] resp1    = 16'h0;
    logic [47:0] result1;
    logic [3:0]  upd1;
    logic        busy1;

    a2d_seq #(
        .NUM_CH(4), .CH_MAP({3'd4, 3'd3, 3'd1, 3'd0}), .PERIOD_W(6), .AVG_LOG2(2)
    ) u_dut1 (
        .clk(clk), .rst(rst), .auto_en(auto_en1), .trig(trig1), .ch_en(ch_en1),
        .snd(snd1), .cmd(cmd1), .done(done1), .resp(resp1),
        .result(result1), .upd(upd1), .busy(busy1)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Physical ADC channel back to logical slot (7 marks an unexpected channel).
    function automatic logic [2:0] chan2slot(input logic [2:0] ch);
        case (ch)
            3'd0:    return 3'd0;
            3'd1:    return 3'd1;
            3'd3:    return 3'd2;
            3'd4:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    // ---------------- SPI master models ----------------
    int   lat0 = 0, lat1 = 0;
    bit   pend0 = 0, pend1 = 0;
    bit   ph0 = 0, ph1 = 0;
    int   rd_idx1 = 0;
    logic [11:0] rd_tab [4] = '{12'h100, 12'h101, 12'h102, 12'h105};

    always @(negedge clk) begin
        if (rst) begin
            done0 = 1'b0; resp0 = 16'h0; pend0 = 0; lat0 = 0; ph0 = 0;
        end else begin
            if (pend0) begin
                pend0 = 0; done0 = 1'b0; lat0 = 3;
            end else if (lat0 > 0) begin
                lat0--;
                if (lat0 == 0) begin
                    done0 = 1'b1;
                    resp0 = ph0 ? {4'hF, 12'h100 + 12'(chan2slot(cmd0[13:11]))} : 16'h0EEE;
                    ph0   = ~ph0;
                end
            end
            if (snd0 === 1'b1) pend0 = 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            done1 = 1'b0; resp1 = 16'h0; pend1 = 0; lat1 = 0; ph1 = 0; rd_idx1 = 0;
        end else begin
            if (pend1) begin
                pend1 = 0; done1 = 1'b0; lat1 = 2;
            end else if (lat1 > 0) begin
                lat1--;
                if (lat1 == 0) begin
                    done1 = 1'b1;
                    if (ph1) begin
                        resp1   = {4'hA, rd_tab[rd_idx1]};
                        rd_idx1 = (rd_idx1 + 1) % 4;
                    end else begin
                        resp1 = 16'h0EEE;
                    end
                    ph1 = ~ph1;
                end
            end
            if (snd1 === 1'b1) pend1 = 1;
        end
    end

    // ---------------- monitors ----------------
    int snd_cnt0 = 0, upd_cnt0 = 0, busy_cnt0 = 0;
    int snd_cnt1 = 0, upd_cnt1 = 0;

    always @(negedge clk) begin
        if (snd0 === 1'b1) snd_cnt0++;
        if (busy0 === 1'b1) busy_cnt0++;
        if (upd0 != 4'h0) begin
            upd_cnt0++;
            chk("upd0_onehot", 64'($onehot(upd0)), 64'd1);
        end
        if (snd1 === 1'b1) snd_cnt1++;
        if (upd1 != 4'h0) begin
            upd_cnt1++;
            chk("upd1_onehot", 64'($onehot(upd1)), 64'd1);
        end
    end

    // ---------------- driver tasks ----------------
    // One triggered burst on instance 0; reports t+1 observations and the upd.
    task automatic burst0(input logic [3:0] en, output logic [15:0] c, output logic b1,
                          output logic s1, output logic ok, output logic [3:0] u,
                          output logic [47:0] r, output logic bz, output int ns);
        int base;
        ch_en0 = en;
        @(posedge clk); #1;
        base  = snd_cnt0;
        trig0 = 1'b1;
        @(posedge clk); #1;
        trig0 = 1'b0;
        c = cmd0; b1 = busy0; s1 = snd0;
        ok = 1'b0; u = 4'h0; r = '0; bz = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #1;
            if (upd0 != 4'h0) begin
                ok = 1'b1; u = upd0; r = result0; bz = busy0;
            end
        end
        ns = snd_cnt0 - base;
    endtask

    // One triggered burst on instance 1; ch_en is switched to en_mid mid-burst.
    task automatic burst1(input logic [3:0] en, input logic [3:0] en_mid, output logic ok,
                          output logic [3:0] u, output logic [47:0] r, output logic bz,
                          output int ns, output int nu);
        int sbase, ubase;
        ch_en1 = en;
        @(posedge clk); #1;
        sbase = snd_cnt1;
        ubase = upd_cnt1;
        trig1 = 1'b1;
        @(posedge clk); #1;
        trig1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 ch_en1 = en_mid;
        ok = 1'b0; u = 4'h0; r = '0; bz = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk); #1;
            if (upd1 != 4'h0) begin
                ok = 1'b1; u = upd1; r = result1; bz = busy1;
            end
        end
        repeat (10) @(posedge clk);
        #1;
        ns = snd_cnt1 - sbase;
        nu = upd_cnt1 - ubase;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [3:0]  en;
        logic [15:0] cmd;
        logic [1:0]  slot;
        logic [11:0] val;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [15:0] c;
        logic        b1, s1, ok, bz;
        logic [3:0]  u, exp_u;
        logic [47:0] r, exp_res0;
        int          ns, nu, sbase, ubase, bbase;

        vecs[0]  = '{4'hF, 16'h0000, 2'd0, 12'h100};
        vecs[1]  = '{4'hF, 16'h0800, 2'd1, 12'h101};
        vecs[2]  = '{4'hF, 16'h1800, 2'd2, 12'h102};
        vecs[3]  = '{4'hF, 16'h2000, 2'd3, 12'h103};
        vecs[4]  = '{4'hF, 16'h0000, 2'd0, 12'h100};
        vecs[5]  = '{4'h5, 16'h1800, 2'd2, 12'h102};
        vecs[6]  = '{4'h5, 16'h0000, 2'd0, 12'h100};
        vecs[7]  = '{4'h5, 16'h1800, 2'd2, 12'h102};
        vecs[8]  = '{4'h5, 16'h0000, 2'd0, 12'h100};
        vecs[9]  = '{4'h8, 16'h2000, 2'd3, 12'h103};
        vecs[10] = '{4'h2, 16'h0800, 2'd1, 12'h101};
        exp_res0 = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_snd", 64'(snd0), 0);
        chk("rst_cmd", 64'(cmd0), 0);
        chk("rst_result", 64'(result0), 0);
        chk("rst_upd", 64'(upd0), 0);
        chk("rst_busy", 64'(busy0), 0);
        chk("rst_result1", 64'(result1), 0);
        rst = 1'b0;

        // Round-robin and masked selection, one triggered burst per vector.
        for (int i = 0; i < 11; i++) begin
            burst0(vecs[i].en, c, b1, s1, ok, u, r, bz, ns);
            exp_res0[12*int'(vecs[i].slot) +: 12] = vecs[i].val;
            exp_u = 4'h1 << vecs[i].slot;
            chk($sformatf("v%0d_cmd", i), 64'(c), 64'(vecs[i].cmd));
            chk($sformatf("v%0d_busy_t1", i), 64'(b1), 1);
            chk($sformatf("v%0d_snd_t1", i), 64'(s1), 1);
            chk($sformatf("v%0d_upd_seen", i), 64'(ok), 1);
            chk($sformatf("v%0d_upd", i), 64'(u), 64'(exp_u));
            chk($sformatf("v%0d_result", i), 64'(r), 64'(exp_res0));
            chk($sformatf("v%0d_busy_at_upd", i), 64'(bz), 0);
            chk($sformatf("v%0d_snd_count", i), 64'(ns), 2);
        end

        // Periodic conversion from the interval tick; ptr is now at slot 2.
        ch_en0   = 4'hF;
        auto_en0 = 1'b1;
        ok = 1'b0; u = 4'h0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            if (upd0 != 4'h0) begin
                ok = 1'b1; u = upd0; r = result0;
            end
        end
        auto_en0 = 1'b0;
        chk("auto_upd_seen", 64'(ok), 1);
        chk("auto_upd", 64'(u), 64'h4);
        chk("auto_result", 64'(r), 64'(exp_res0));

        // Empty mask: no activity across more than three tick periods.
        ch_en0 = 4'h0;
        auto_en0 = 1'b1;
        @(posedge clk); #1;
        sbase = snd_cnt0; ubase = upd_cnt0; bbase = busy_cnt0;
        trig0 = 1'b1;
        @(posedge clk); #1;
        trig0 = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        auto_en0 = 1'b0;
        chk("mask0_snd", 64'(snd_cnt0 - sbase), 0);
        chk("mask0_busy", 64'(busy_cnt0 - bbase), 0);
        chk("mask0_upd", 64'(upd_cnt0 - ubase), 0);

        // Trigger while busy is dropped; ptr is now at slot 3.
        ch_en0 = 4'hF;
        @(posedge clk); #1;
        sbase = snd_cnt0; ubase = upd_cnt0;
        trig0 = 1'b1;
        @(posedge clk); #1;
        trig0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("trig_busy_before", 64'(busy0), 1);
        trig0 = 1'b1;
        @(posedge clk); #1;
        trig0 = 1'b0;
        ok = 1'b0; u = 4'h0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #1;
            if (upd0 != 4'h0) begin
                ok = 1'b1; u = upd0; r = result0;
            end
        end
        chk("trig_upd", 64'(u), 64'h8);
        chk("trig_result", 64'(r), 64'(exp_res0));
        repeat (40) @(posedge clk);
        #1;
        chk("trig_snd_total", 64'(snd_cnt0 - sbase), 2);
        chk("trig_upd_total", 64'(upd_cnt0 - ubase), 1);
        chk("trig_idle_after", 64'(busy0), 0);

        // Reset held 3 cycles in the middle of a read transaction.
        @(posedge clk); #1;
        sbase = snd_cnt0; ubase = upd_cnt0;
        trig0 = 1'b1;
        @(posedge clk); #1;
        trig0 = 1'b0;
        for (int i = 0; i < 100 && snd_cnt0 < sbase + 2; i++) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_reached_read", 64'(snd_cnt0 - sbase), 2);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid_snd", 64'(snd0), 0);
        chk("rstmid_cmd", 64'(cmd0), 0);
        chk("rstmid_result", 64'(result0), 0);
        chk("rstmid_upd", 64'(upd0), 0);
        chk("rstmid_busy", 64'(busy0), 0);
        rst = 1'b0;
        sbase = snd_cnt0;
        repeat (30) @(posedge clk);
        #1;
        chk("rstmid_no_snd", 64'(snd_cnt0 - sbase), 0);
        chk("rstmid_no_upd", 64'(upd_cnt0 - ubase), 0);
        exp_res0 = '0;
        burst0(4'hF, c, b1, s1, ok, u, r, bz, ns);
        exp_res0[11:0] = 12'h100;
        chk("post_rst_cmd", 64'(c), 64'h0000);
        chk("post_rst_upd", 64'(u), 64'h1);
        chk("post_rst_result", 64'(r), 64'(exp_res0));
        chk("post_rst_snd_count", 64'(ns), 2);

        // Averaging: reads 0x100, 0x101, 0x102, 0x105 average to 0x102.
        burst1(4'h1, 4'h1, ok, u, r, bz, ns, nu);
        chk("avg1_upd_seen", 64'(ok), 1);
        chk("avg1_upd", 64'(u), 64'h1);
        chk("avg1_result", 64'(r), 64'h000_000_000_102);
        chk("avg1_busy_at_upd", 64'(bz), 0);
        chk("avg1_snd_count", 64'(ns), 8);
        chk("avg1_upd_count", 64'(nu), 1);

        // Mask change mid-burst does not abort slot 2; slot 0 holds its value.
        burst1(4'h4, 4'h1, ok, u, r, bz, ns, nu);
        chk("avg2_upd", 64'(u), 64'h4);
        chk("avg2_result", 64'(r), 64'h000_102_000_102);
        chk("avg2_snd_count", 64'(ns), 8);
        chk("avg2_upd_count", 64'(nu), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
